// File: rtl/rf_pkg.sv
// Shared constants and types for the reg_file_2r1w register file.
package rf_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = 5'd0;

endpackage : rf_pkg

// File: rtl/rf_cell.sv
// One WIDTH-bit register with load enable and asynchronous active-low clear.
module rf_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage flop: cleared by reset, loads d when selected, otherwise recirculates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule : rf_cell

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write register file with x0 hardwired to zero.
// Optional same-cycle write forwarding to the read ports: define RF_WRITE_BYPASS_EN.
module reg_file_2r1w
    import rf_pkg::*;
#(
    parameter  int WIDTH = XLEN,
    parameter  int DEPTH = NREGS,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] entry_s [DEPTH];

    // Entry 0 has no storage; it always reads as zero.
    assign entry_s[0] = '0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_cell
        logic load_s;

        // One-hot write decode, gated by we.
        assign load_s = we & (waddr == AW'(i));

        rf_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .load (load_s),
            .d    (wdata),
            .q    (entry_s[i])
        );
    end

`ifdef RF_WRITE_BYPASS_EN
    logic wr_valid_s;

    // A write that will actually land; reads during reset stay at zero.
    assign wr_valid_s = we & rst & (waddr != AW'(ZERO_REG));

    // Read ports with write-first forwarding from the writeback stage.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (wr_valid_s && (raddr1 == waddr)) begin
            rdata1 = wdata;
        end else begin
            rdata1 = entry_s[raddr1];
        end
        if (wr_valid_s && (raddr2 == waddr)) begin
            rdata2 = wdata;
        end else begin
            rdata2 = entry_s[raddr2];
        end
    end
`else
    // Plain combinational read ports; same-cycle writes become visible next cycle.
    always_comb begin
        rdata1 = entry_s[raddr1];
        rdata2 = entry_s[raddr2];
    end
`endif

endmodule : reg_file_2r1w

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Parametrised general-purpose register file for the RISC-V core. Successor to the single load-enabled register: DEPTH registers of WIDTH bits each.
- Two read ports and one write port. Entry 0 is hardwired to zero (x0).
- Sits between the decode stage, which reads rs1/rs2, and the writeback stage, which writes rd.

Parameters:
- WIDTH, 32, data width of each register in bits
- DEPTH, 32, number of registers (power of two, at least 2)
- AW, $clog2(DEPTH), address width (derived; never overridden)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (clears all entries)
- we  input  1  write enable, sampled on rising clk
- waddr  input  AW  write address (rd)
- wdata  input  WIDTH  write data
- raddr1  input  AW  read port 1 address (rs1)
- raddr2  input  AW  read port 2 address (rs2)
- rdata1  output  WIDTH  read port 1 data
- rdata2  output  WIDTH  read port 2 data

Behaviour:
- One clock. Reset is asynchronous and active-low: rst=0 immediately forces every entry to 0, independent of clk. rdata1 and rdata2 therefore read 0 during reset and in the first cycle after it.
- Write: on a rising clk edge with rst=1, we=1 and waddr!=0, entry[waddr] takes wdata. Otherwise every entry holds its value, in the same way the load mux recirculates Q.
- Writes to address 0 are discarded. Entry 0 is constant 0 and carries no flop.
- Read: combinational, zero latency. rdata1 = entry[raddr1] and rdata2 = entry[raddr2]. Address 0 always returns 0.
- Both read ports may address the same entry, and either may equal waddr.
- Read during write to the same address, without the bypass macro: the read returns the old value in that cycle and the new value from the next cycle.
- Reset asserted in the middle of a write: the reset wins, and the entry is 0 after the edge.
- A release of rst coinciding with a clk edge and we=1 has no guaranteed effect on that edge.
- Widths: addresses are unsigned AW bits; no address is out of range because DEPTH = 2^AW.
- No X on outputs after reset for any address.

Optional Feature:
- Macro RF_WRITE_BYPASS_EN.
- When defined: if we=1, waddr!=0 and raddrN==waddr, then rdataN = wdata in the same cycle (write-first forwarding), so writeback-to-decode needs no stall. Address 0 still reads 0.
- When undefined: plain read-old behaviour as in Behaviour, and no bypass comparators are built.

Decomposition:
- Shared package rf_pkg holds:
  - XLEN = 32 and NREGS = 32 constants
  - the reg_addr_t typedef, logic [4:0]
  - the ZERO_REG = 0 constant
- One sub-module: rf_cell, a WIDTH-bit register with load enable and asynchronous active-low clear.
- rf_cell is instantiated DEPTH-1 times in a generate loop; its load input is the one-hot decode of waddr gated by we.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with random addresses -> rdata1 and rdata2 are 0x00000000 for every raddr 0..31.
- Basic write/read: write 0xDEADBEEF to entry 5, next cycle raddr1=5 and raddr2=5 -> both read 0xDEADBEEF.
- x0 protection: we=1, waddr=0, wdata=0xFFFFFFFF, then raddr1=0 -> reads 0x00000000.
- Same-cycle read/write:
  - Setup: entry 7 holds 0x11111111; write 0x22222222 to entry 7 with raddr1=7.
  - Without the macro: the same cycle reads 0x11111111 and the next cycle reads 0x22222222.
  - With RF_WRITE_BYPASS_EN: the same cycle reads 0x22222222.
- Async reset in the middle of a write: fill entries 1..31 with their index, then pulse rst low between clk edges -> all reads are 0 immediately, with no clock edge needed.
- we=0 hold: write 0xA5A5A5A5 to entry 31, then drive we=0 with wdata=0 for 10 cycles -> entry 31 still reads 0xA5A5A5A5.
